pulse_sequencer: RTL and testbench

Scheduler that drives one `pulse_generator` instance through a programmable list of pulse-train segments. Each segment has a pulse width, a period and a pulse count. The block owns the generator's `pulse_width`, `pulse_period` and `rst` inputs, and watches its `start` flag to count periods. It sits between the register bank (segment programming, arm/trigger/abort) and the generator.

---
 rtl/pulse_sequencer_pkg.sv | 28 ++
 rtl/pulse_segment_table.sv | 32 +++
 rtl/pulse_sequencer.sv | 147 ++++++++++++++
 tb/tb_pulse_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sequencer_pkg.sv
// rtl/pulse_sequencer_pkg.sv - shared state, segment and reset definitions for pulse_sequencer
package pulse_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int SEG_WIDTH_W  = 8;
  localparam int SEG_PERIOD_W = 16;
  localparam int SEG_COUNT_W  = 16;

  typedef struct packed {
    logic [SEG_WIDTH_W-1:0]  width;
    logic [SEG_PERIOD_W-1:0] period;
    logic [SEG_COUNT_W-1:0]  count;
  } seg_t;

  localparam logic [SEG_WIDTH_W-1:0]  RST_WIDTH  = '0;
  localparam logic [SEG_PERIOD_W-1:0] RST_PERIOD = SEG_PERIOD_W'(2);

  // A programmed count of zero still emits one pulse.
  function automatic logic [SEG_COUNT_W-1:0] eff_count(input logic [SEG_COUNT_W-1:0] c);
    return (c == '0) ? SEG_COUNT_W'(1) : c;
  endfunction

endpackage

// File: rtl/pulse_segment_table.sv
// rtl/pulse_segment_table.sv - segment register file, synchronous write, asynchronous reads
module pulse_segment_table
  import pulse_sequencer_pkg::*;
#(
  parameter int N_SEGMENTS = 4,
  localparam int SEG_AW = $clog2(N_SEGMENTS)
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [SEG_AW-1:0]       wr_addr_i,
  input  seg_t                    wr_data_i,
  input  logic [SEG_AW-1:0]       rd_addr_a_i,
  output logic [SEG_COUNT_W-1:0]  rd_count_a_o,
  input  logic [SEG_AW-1:0]       rd_addr_b_i,
  output logic [SEG_WIDTH_W-1:0]  rd_width_b_o,
  output logic [SEG_PERIOD_W-1:0] rd_period_b_o
);

  seg_t mem_q [N_SEGMENTS];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Port A serves the running segment's count, port B the segment about to be loaded.
  assign rd_count_a_o  = mem_q[rd_addr_a_i].count;
  assign rd_width_b_o  = mem_q[rd_addr_b_i].width;
  assign rd_period_b_o = mem_q[rd_addr_b_i].period;

endmodule

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - runs a pulse_generator through a list of width/period/count segments
// Optional list looping is enabled by defining PULSE_SEQUENCER_LOOP_EN.
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int PULSE_WIDTH_WIDTH  = SEG_WIDTH_W,
  parameter int PULSE_PERIOD_WIDTH = SEG_PERIOD_W,
  parameter int COUNT_WIDTH        = SEG_COUNT_W,
  parameter int N_SEGMENTS         = 4,
  localparam int SEG_AW = $clog2(N_SEGMENTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_wr,
  input  logic [SEG_AW-1:0]             cfg_addr,
  input  logic [PULSE_WIDTH_WIDTH-1:0]  cfg_width,
  input  logic [PULSE_PERIOD_WIDTH-1:0] cfg_period,
  input  logic [COUNT_WIDTH-1:0]        cfg_count,
  input  logic [SEG_AW-1:0]             cfg_last,
  input  logic                          arm,
  input  logic                          trigger,
  input  logic                          abort,
`ifdef PULSE_SEQUENCER_LOOP_EN
  input  logic                          loop,
`endif
  input  logic                          gen_start,
  output logic [PULSE_WIDTH_WIDTH-1:0]  gen_pulse_width,
  output logic [PULSE_PERIOD_WIDTH-1:0] gen_pulse_period,
  output logic                          gen_rst,
  output logic                          busy,
  output logic                          done,
  output logic [SEG_AW-1:0]             seg_idx,
  output logic [COUNT_WIDTH-1:0]        pulse_cnt
);

  state_t                        state_q;
  logic [SEG_AW-1:0]             seg_idx_q, last_q, seg_nxt;
  logic [COUNT_WIDTH-1:0]        pulse_cnt_q;
  logic [PULSE_WIDTH_WIDTH-1:0]  width_q;
  logic [PULSE_PERIOD_WIDTH-1:0] period_q;
  logic                          gen_rst_q, busy_q, done_q;
  logic                          loop_act, seg_end;
  logic [COUNT_WIDTH-1:0]        cur_count;
  logic [PULSE_WIDTH_WIDTH-1:0]  nxt_width;
  logic [PULSE_PERIOD_WIDTH-1:0] nxt_period;
  logic [SEG_AW-1:0]             rd_b_addr;

`ifdef PULSE_SEQUENCER_LOOP_EN
  assign loop_act = loop;
`else
  assign loop_act = 1'b0;
`endif

  assign seg_end   = (seg_idx_q == last_q);
  assign seg_nxt   = seg_end ? '0 : seg_idx_q + 1'b1;
  // Before the run starts the next segment to load is always entry 0.
  assign rd_b_addr = (state_q == RUN) ? seg_nxt : '0;

  pulse_segment_table #(
    .N_SEGMENTS(N_SEGMENTS)
  ) u_table (
    .clk          (clk),
    .wr_en_i      (cfg_wr && (state_q == IDLE)),
    .wr_addr_i    (cfg_addr),
    .wr_data_i    ('{width: cfg_width, period: cfg_period, count: cfg_count}),
    .rd_addr_a_i  (seg_idx_q),
    .rd_count_a_o (cur_count),
    .rd_addr_b_i  (rd_b_addr),
    .rd_width_b_o (nxt_width),
    .rd_period_b_o(nxt_period)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      seg_idx_q   <= '0;
      last_q      <= '0;
      pulse_cnt_q <= '0;
      width_q     <= RST_WIDTH;
      period_q    <= RST_PERIOD;
      gen_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      gen_rst_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        width_q     <= RST_WIDTH;
        seg_idx_q   <= '0;
        pulse_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (arm) begin
              state_q <= ARMED;
              busy_q  <= 1'b1;
            end
          end
          ARMED: begin
            if (trigger) begin
              state_q     <= RUN;
              last_q      <= cfg_last;
              seg_idx_q   <= '0;
              pulse_cnt_q <= '0;
              width_q     <= nxt_width;
              period_q    <= nxt_period;
              gen_rst_q   <= 1'b1;
            end
          end
          RUN: begin
            // A start seen while the generator is being restarted belongs to the old train.
            if (gen_start && !gen_rst_q) begin
              if (pulse_cnt_q < eff_count(cur_count)) begin
                pulse_cnt_q <= pulse_cnt_q + 1'b1;
              end else if (seg_end && !loop_act) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                width_q <= RST_WIDTH;
                done_q  <= 1'b1;
              end else begin
                seg_idx_q   <= seg_nxt;
                width_q     <= nxt_width;
                period_q    <= nxt_period;
                pulse_cnt_q <= COUNT_WIDTH'(1);
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gen_pulse_width  = width_q;
  assign gen_pulse_period = period_q;
  assign gen_rst          = gen_rst_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign seg_idx          = seg_idx_q;
  assign pulse_cnt        = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - scoreboard bench for pulse_sequencer with a behavioural generator
// Loop scenario is exercised when PULSE_SEQUENCER_LOOP_EN is defined.
module tb_pulse_sequencer;
  import pulse_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_width = '0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_count = '0;
  logic [1:0]  cfg_last = '0;
  logic        arm = 1'b0, trigger = 1'b0, abort = 1'b0;
  logic        loop = 1'b0;
  logic        gen_start;
  logic [7:0]  gen_pulse_width;
  logic [15:0] gen_pulse_period;
  logic        gen_rst, busy, done;
  logic [1:0]  seg_idx;
  logic [15:0] pulse_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pulse_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_wr          (cfg_wr),
    .cfg_addr        (cfg_addr),
    .cfg_width       (cfg_width),
    .cfg_period      (cfg_period),
    .cfg_count       (cfg_count),
    .cfg_last        (cfg_last),
    .arm             (arm),
    .trigger         (trigger),
    .abort           (abort),
`ifdef PULSE_SEQUENCER_LOOP_EN
    .loop            (loop),
`endif
    .gen_start       (gen_start),
    .gen_pulse_width (gen_pulse_width),
    .gen_pulse_period(gen_pulse_period),
    .gen_rst         (gen_rst),
    .busy            (busy),
    .done            (done),
    .seg_idx         (seg_idx),
    .pulse_cnt       (pulse_cnt)
  );

  // Generator: counter restarts on gen_rst, start is registered from counter==0.
  logic [15:0] g_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      g_cnt     <= '0;
      gen_start <= 1'b0;
    end else if (gen_rst) begin
      g_cnt     <= '0;
      gen_start <= 1'b0;
    end else begin
      gen_start <= (g_cnt == 16'd0);
      g_cnt     <= (g_cnt >= gen_pulse_period - 16'd1) ? 16'd0 : g_cnt + 16'd1;
    end
  end

  typedef struct {
    bit grst;
    int seg;
    int cnt;
    int w;
    int p;
    bit dn;
    bit bz;
    bit ci;
    int gap;
  } exp_t;

  exp_t exp_q[$];

  int   cyc = 0, last_start_cyc = 0, cur_gap = 0;
  logic start_q = 1'b0, run_act = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gen_start) begin
      cur_gap        <= cyc - last_start_cyc;
      last_start_cyc <= cyc;
    end
    start_q <= gen_start && busy && run_act && !gen_rst && !rst;
    if (rst) run_act <= 1'b0;
    else if (gen_rst) run_act <= 1'b1;
    else if (!busy) run_act <= 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && (start_q || gen_rst || done)) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: seg=%0d cnt=%0d w=%0d p=%0d rst=%0b done=%0b busy=%0b, none required",
                 seg_idx, pulse_cnt, gen_pulse_width, gen_pulse_period, gen_rst, done, busy);
      end else begin
        exp_t e;
        bit ok;
        e  = exp_q.pop_front();
        ok = (gen_rst == e.grst) && (done == e.dn) && (busy == e.bz) &&
             (32'(gen_pulse_width) == e.w) && (32'(gen_pulse_period) == e.p) &&
             (!e.ci || ((32'(seg_idx) == e.seg) && (32'(pulse_cnt) == e.cnt))) &&
             ((e.gap == 0) || (cur_gap == e.gap));
        if (!ok) begin
          n_fail++;
          $display("FAIL event: got rst=%0b seg=%0d cnt=%0d w=%0d p=%0d done=%0b busy=%0b gap=%0d; required rst=%0b seg=%0d cnt=%0d w=%0d p=%0d done=%0b busy=%0b gap=%0d",
                   gen_rst, seg_idx, pulse_cnt, gen_pulse_width, gen_pulse_period, done, busy, cur_gap,
                   e.grst, e.seg, e.cnt, e.w, e.p, e.dn, e.bz, e.gap);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic push(input bit grst, input int seg, input int cnt, input int w, input int p,
                      input bit dn, input bit bz, input bit ci, input int gap);
    exp_t e;
    e = '{grst: grst, seg: seg, cnt: cnt, w: w, p: p, dn: dn, bz: bz, ci: ci, gap: gap};
    exp_q.push_back(e);
  endtask

  // All drive tasks are entered at a negedge and return at the following negedge.
  task automatic wr(input int a, input int w, input int p, input int c);
    cfg_wr     = 1'b1;
    cfg_addr   = 2'(a);
    cfg_width  = 8'(w);
    cfg_period = 16'(p);
    cfg_count  = 16'(c);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; @(negedge clk); arm = 1'b0;
  endtask

  task automatic do_trig();
    trigger = 1'b1; @(negedge clk); trigger = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(nm, int'(busy), 0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_width"}, int'(gen_pulse_width), 0);
    chk({nm, "_period"}, int'(gen_pulse_period), 2);
    chk({nm, "_gen_rst"}, int'(gen_rst), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_seg_idx"}, int'(seg_idx), 0);
    chk({nm, "_pulse_cnt"}, int'(pulse_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Ignored strobes and arm+trigger together
    do_trig();
    chk("trig_in_idle_busy", int'(busy), 0);
    arm = 1'b1; trigger = 1'b1;
    @(negedge clk);
    arm = 1'b0; trigger = 1'b0;
    chk("arm_trig_busy", int'(busy), 1);
    chk("arm_trig_no_genrst", int'(gen_rst), 0);
    @(negedge clk);
    chk("arm_trig_still_no_genrst", int'(gen_rst), 0);
    do_abort();
    chk("abort_armed_busy", int'(busy), 0);

    // Two-segment run
    wr(0, 2, 5, 3);
    wr(1, 1, 4, 2);
    cfg_last = 2'd1;
    do_arm();
    push(1, 0, 0, 2, 5, 0, 1, 1, 0);
    push(0, 0, 1, 2, 5, 0, 1, 1, 0);
    push(0, 0, 2, 2, 5, 0, 1, 1, 5);
    push(0, 0, 3, 2, 5, 0, 1, 1, 5);
    push(0, 1, 1, 1, 4, 0, 1, 1, 5);
    push(0, 1, 2, 1, 4, 0, 1, 1, 4);
    push(0, 0, 0, 0, 4, 1, 0, 0, 4);
    do_trig();
    repeat (5) @(negedge clk);
    do_arm();
    wait_idle("run_a_timeout", 200);
    repeat (2) @(negedge clk);
    chk("run_a_queue_empty", exp_q.size(), 0);
    chk("run_a_width_after", int'(gen_pulse_width), 0);

    // Abort during seg1 pulse 1, with a table write attempted mid-run
    do_arm();
    push(1, 0, 0, 2, 5, 0, 1, 1, 0);
    push(0, 0, 1, 2, 5, 0, 1, 1, 0);
    push(0, 0, 2, 2, 5, 0, 1, 1, 5);
    push(0, 0, 3, 2, 5, 0, 1, 1, 5);
    push(0, 1, 1, 1, 4, 0, 1, 1, 5);
    do_trig();
    wr(0, 7, 9, 5);
    begin
      int i = 0;
      while (seg_idx != 2'd1 && i < 100) begin
        @(negedge clk);
        i++;
      end
      chk("abort_wait_seg1", int'(seg_idx), 1);
    end
    do_abort();
    chk("abort_busy", int'(busy), 0);
    chk("abort_width", int'(gen_pulse_width), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_seg_idx", int'(seg_idx), 0);
    chk("abort_pulse_cnt", int'(pulse_cnt), 0);
    repeat (6) @(negedge clk);
    chk("abort_queue_empty", exp_q.size(), 0);

    // Entry 0 must still hold {2,5,3}
    do_arm();
    push(1, 0, 0, 2, 5, 0, 1, 1, 0);
    do_trig();
    do_abort();
    chk("wr_ignored_queue_empty", exp_q.size(), 0);

    // Count of zero emits exactly one pulse
    wr(0, 3, 6, 0);
    wr(1, 1, 4, 1);
    do_arm();
    push(1, 0, 0, 3, 6, 0, 1, 1, 0);
    push(0, 0, 1, 3, 6, 0, 1, 1, 0);
    push(0, 1, 1, 1, 4, 0, 1, 1, 6);
    push(0, 0, 0, 0, 4, 1, 0, 0, 4);
    do_trig();
    wait_idle("count0_timeout", 200);
    repeat (2) @(negedge clk);
    chk("count0_queue_empty", exp_q.size(), 0);

`ifdef PULSE_SEQUENCER_LOOP_EN
    wr(0, 1, 3, 2);
    cfg_last = 2'd0;
    loop = 1'b1;
    do_arm();
    push(1, 0, 0, 1, 3, 0, 1, 1, 0);
    push(0, 0, 1, 1, 3, 0, 1, 1, 0);
    push(0, 0, 2, 1, 3, 0, 1, 1, 3);
    push(0, 0, 1, 1, 3, 0, 1, 1, 3);
    push(0, 0, 2, 1, 3, 0, 1, 1, 3);
    push(0, 0, 1, 1, 3, 0, 1, 1, 3);
    push(0, 0, 2, 1, 3, 0, 1, 1, 3);
    do_trig();
    begin
      int i = 0;
      while (exp_q.size() != 0 && i < 200) begin
        @(negedge clk);
        i++;
      end
      chk("loop_wait_records", exp_q.size(), 0);
    end
    push(0, 0, 0, 0, 3, 1, 0, 0, 3);
    loop = 1'b0;
    wait_idle("loop_exit_timeout", 100);
    repeat (2) @(negedge clk);
    chk("loop_queue_empty", exp_q.size(), 0);
    cfg_last = 2'd1;
`endif

    // Asynchronous reset in the middle of a run
    wr(0, 2, 5, 3);
    do_arm();
    push(1, 0, 0, 2, 5, 0, 1, 1, 0);
    push(0, 0, 1, 2, 5, 0, 1, 1, 0);
    do_trig();
    begin
      int i = 0;
      while (pulse_cnt != 16'd1 && i < 100) begin
        @(negedge clk);
        i++;
      end
      chk("rst_wait_cnt1", int'(pulse_cnt), 1);
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
